// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register block: FSM state encoding
// and bus-level ACK/NACK values. Build option I2C_TARGET_FILTER_EN is
// consumed by i2c_line_sync.
package i2c_pkg;

  // FSM state encoding, kept as plain constants for legacy tooling.
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RACK_WAIT = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  // Level seen on SDA during the acknowledge bit.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Input conditioning for one open-drain I2C line: 2-flop synchronizer,
// optional glitch filter (enabled by defining I2C_TARGET_FILTER_EN), and
// rise/fall detection on the conditioned level.
module i2c_line_sync #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic ICE_CLK,
  input  logic ICE_RST,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

`ifdef I2C_TARGET_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif
  localparam int DEPTH = FILTER_ON ? FILTER_CYCLES : 0;
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic meta;
  logic synced;
  logic filt;
  logic prev;

  // Two-flop synchronizer; resets to the idle (pulled-up) bus level so no
  // false edge appears when reset is released.
  always_ff @(posedge ICE_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (ICE_RST) begin
      meta   <= 1'b1;
      synced <= 1'b1;
    end else begin
      meta   <= pin;
      synced <= meta;
    end
  end

  generate
    if (DEPTH > 0) begin : g_filter
      logic [CW-1:0] cnt;

      // Accept a new level only after DEPTH consecutive differing samples.
      always_ff @(posedge ICE_CLK) begin
        if (ICE_RST) begin
          filt <= 1'b1;
          cnt  <= '0;
        end else if (synced == filt) begin
          cnt <= '0;
        end else if (cnt == CW'(DEPTH - 1)) begin
          filt <= synced;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else begin : g_bypass
      assign filt = synced;
    end
  endgenerate

  // Previous conditioned level for edge detection.
  always_ff @(posedge ICE_CLK) begin
    if (ICE_RST) prev <= 1'b1;
    else         prev <= filt;
  end

  assign level = filt;
  assign rise  = filt & ~prev;
  assign fall  = ~filt & prev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small register file to the Pi initiator.
// Write: START, addr+W, pointer, data..., STOP. Read: set pointer, then
// repeated START, addr+R, data... with the pointer auto-incrementing.
// Build option I2C_TARGET_FILTER_EN adds a glitch filter on both lines.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR   = 7'h42,
  parameter int         REG_COUNT     = 8,
  parameter int         FILTER_CYCLES = 3,
  localparam int        AW            = $clog2(REG_COUNT)
) (
  input  logic                   ICE_CLK,
  input  logic                   ICE_RST,
  input  logic                   sda_di,
  input  logic                   scl_di,
  output logic                   sda_oe,
  output logic [8*REG_COUNT-1:0] regs_flat,
  output logic                   wr_strobe,
  output logic [AW-1:0]          wr_addr,
  output logic                   busy
);

  logic sda_lvl, sda_rise, sda_fall;
  logic scl_lvl, scl_rise, scl_fall;

  i2c_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_sync (
    .ICE_CLK (ICE_CLK),
    .ICE_RST (ICE_RST),
    .pin     (sda_di),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  i2c_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_sync (
    .ICE_CLK (ICE_CLK),
    .ICE_RST (ICE_RST),
    .pin     (scl_di),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  logic          start_det, stop_det;
  logic [3:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    rx_byte;
  logic [AW-1:0] ptr;
  logic          rd_mode;
  logic [7:0]    regs [REG_COUNT];

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {shreg[6:0], sda_lvl};

  // Protocol FSM, shift register, pointer and register file.
  always_ff @(posedge ICE_CLK) begin
    if (ICE_RST) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rd_mode   <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      // NOTE: the register file is reset on purpose; software relies on it
      // reading back zero, so it cannot be mapped to a reset-less RAM.
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == TARGET_ADDR) begin
                state   <= ST_ADDR_ACK;
                rd_mode <= rx_byte[0];
                busy    <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          // First SCL fall starts the ACK, second fall ends it.
          ST_ADDR_ACK: if (scl_fall) begin
            bit_cnt <= '0;
            if (!sda_oe) begin
              sda_oe <= ~I2C_ACK;
            end else if (rd_mode) begin
              shreg  <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
              state  <= ST_RDATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= ST_PTR;
            end
          end
          ST_PTR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= rx_byte[AW-1:0];
              state <= ST_PTR_ACK;
            end
          end
          ST_PTR_ACK: if (scl_fall) begin
            bit_cnt <= '0;
            if (!sda_oe) begin
              sda_oe <= ~I2C_ACK;
            end else begin
              sda_oe <= 1'b0;
              state  <= ST_WDATA;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_WDATA_ACK;
          end
          // The byte is committed on the fall that starts the ACK.
          ST_WDATA_ACK: if (scl_fall) begin
            bit_cnt <= '0;
            if (!sda_oe) begin
              sda_oe     <= ~I2C_ACK;
              regs[ptr]  <= shreg;
              wr_strobe  <= 1'b1;
              wr_addr    <= ptr;
              ptr        <= ptr + 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= ST_WDATA;
            end
          end
          // Entered on an SCL fall with bit 7 already driven; bit_cnt counts
          // rises, so a fall seen with bit_cnt wrapped to 0 ends the byte.
          ST_RDATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + 1'b1;
                state  <= ST_RACK_WAIT;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          // A fall here always follows an ACK rise, since NACK leaves first.
          ST_RACK_WAIT: begin
            if (scl_rise && sda_lvl == I2C_NACK) begin
              state <= ST_IGNORE;
              busy  <= 1'b0;
            end else if (scl_fall) begin
              shreg   <= regs[ptr];
              sda_oe  <= ~regs[ptr][7];
              bit_cnt <= '0;
              state   <= ST_RDATA;
            end
          end
          ST_IDLE, ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Flatten the register file onto the output bus.
  always_comb begin
    // NOTE: a default assignment first keeps combinational blocks latch-free.
    regs_flat = '0;
    for (int i = 0; i < REG_COUNT; i++) regs_flat[8*i +: 8] = regs[i];
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: open-drain bus model, directed
// transactions followed by random write/read traffic checked against a
// register-file reference model. Honours I2C_TARGET_FILTER_EN if defined.
module tb_i2c_target_regs;

  localparam int Q = 30;  // quarter SCL period in ICE_CLK cycles (12 MHz / 100 kHz)

  logic        ICE_CLK = 1'b0;
  logic        ICE_RST = 1'b1;
  logic        sda_m   = 1'b1;
  logic        scl_m   = 1'b1;
  wire         sda_line;
  logic        sda_oe;
  logic [63:0] regs_flat;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        busy;

  // Wired-AND with pull-up: low if either side pulls.
  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regs dut (
    .ICE_CLK   (ICE_CLK),
    .ICE_RST   (ICE_RST),
    .sda_di    (sda_line),
    .scl_di    (scl_m),
    .sda_oe    (sda_oe),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  always #42 ICE_CLK = ~ICE_CLK;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model [8];
  int         mptr = 0;
  int         exp_wr[$];
  int         got_wr[$];
  logic [7:0] wq[$];
  logic       sda_pulled = 1'b0;
  logic       busy_seen  = 1'b0;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge ICE_CLK) begin
    if (wr_strobe) got_wr.push_back(int'(wr_addr));
    if (sda_oe) sda_pulled = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #(84 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge ICE_CLK);
  endtask

  // One SCL period; optional SDA-low glitch of g cycles while SCL is high.
  task automatic bit_cycle(input logic b, input int g, output logic r);
    sda_m = b;
    clks(Q);
    scl_m = 1'b1;
    clks(Q);
    r = sda_line;
    if (g > 0) begin
      sda_m = 1'b0;
      clks(g);
      sda_m = b;
    end
    clks(Q);
    scl_m = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b1; clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int gbit, input int glen,
                            output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], (i == gbit) ? glen : 0, r);
    bit_cycle(1'b1, 0, ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 0, r);
      d[i] = r;
    end
    bit_cycle(ack, 0, r);
  endtask

  // Write transaction of pointer p followed by the bytes in wq.
  task automatic write_txn(input string tag, input logic [7:0] p);
    logic ack;
    got_wr.delete();
    exp_wr.delete();
    i2c_start();
    write_byte(8'h84, -1, 0, ack);
    check({tag, "_addr_ack"}, ack, 1'b0);
    write_byte(p, -1, 0, ack);
    check({tag, "_ptr_ack"}, ack, 1'b0);
    mptr = p % 8;
    foreach (wq[k]) begin
      write_byte(wq[k], -1, 0, ack);
      check({tag, "_data_ack"}, ack, 1'b0);
      model[mptr] = wq[k];
      exp_wr.push_back(mptr);
      mptr = (mptr + 1) % 8;
    end
    check({tag, "_busy"}, busy, 1'b1);
    i2c_stop();
    clks(10);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_regs"}, regs_flat, model_flat());
    check({tag, "_nstrobe"}, got_wr.size(), exp_wr.size());
    foreach (exp_wr[k]) if (k < got_wr.size()) check({tag, "_wr_addr"}, got_wr[k], exp_wr[k]);
  endtask

  // Set pointer p, repeated START, read n bytes (last one NACKed).
  task automatic read_txn(input string tag, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h84, -1, 0, ack);
    check({tag, "_addr_ack"}, ack, 1'b0);
    write_byte(p, -1, 0, ack);
    check({tag, "_ptr_ack"}, ack, 1'b0);
    mptr = p % 8;
    i2c_start();
    write_byte(8'h85, -1, 0, ack);
    check({tag, "_raddr_ack"}, ack, 1'b0);
    for (int k = 0; k < n; k++) begin
      read_byte((k == n - 1) ? 1'b1 : 1'b0, d);
      check({tag, "_rdata"}, d, model[mptr]);
      mptr = (mptr + 1) % 8;
    end
    check({tag, "_released"}, sda_oe, 1'b0);
    check({tag, "_nack_busy"}, busy, 1'b0);
    i2c_stop();
    clks(10);
  endtask

  initial begin
    logic ack;
    logic [7:0] p;
    logic [63:0] snap;
    int n;

    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    clks(5);
    ICE_RST = 1'b0;
    clks(5);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 3'd0);
    check("rst_regs", regs_flat, 64'd0);

    // 1. basic write
    wq = '{8'hA5, 8'h5A};
    write_txn("t1", 8'h02);
    check("t1_reg2", regs_flat[23:16], 8'hA5);
    check("t1_reg3", regs_flat[31:24], 8'h5A);

    // 2. pointer wrap
    wq = '{8'h11, 8'h22};
    write_txn("t2", 8'h07);
    check("t2_reg7", regs_flat[63:56], 8'h11);
    check("t2_reg0", regs_flat[7:0], 8'h22);

    // 3. restart read with ACK then NACK
    read_txn("t3", 8'h02, 2);

    // 4. wrong address is ignored
    snap = regs_flat;
    sda_pulled = 1'b0;
    busy_seen  = 1'b0;
    i2c_start();
    write_byte(8'h86, -1, 0, ack);
    check("t4_addr_nack", ack, 1'b1);
    write_byte(8'h33, -1, 0, ack);
    check("t4_data_nack", ack, 1'b1);
    i2c_stop();
    clks(10);
    check("t4_sda_never_low", sda_pulled, 1'b0);
    check("t4_busy_never", busy_seen, 1'b0);
    check("t4_regs", regs_flat, snap);

    // 5. reset while the target drives bit 7 (=0) of reg0
    i2c_start();
    write_byte(8'h84, -1, 0, ack);
    write_byte(8'h00, -1, 0, ack);
    i2c_start();
    write_byte(8'h85, -1, 0, ack);
    check("t5_driving", sda_oe, 1'b1);
    ICE_RST = 1'b1;
    clks(1);
    check("t5_rst_sda_oe", sda_oe, 1'b0);
    check("t5_rst_regs", regs_flat, 64'd0);
    check("t5_rst_busy", busy, 1'b0);
    ICE_RST = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    clks(Q);
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    wq = '{8'h3C};
    write_txn("t5", 8'h01);

    // 6. SDA glitch while SCL high during the MSB of a data byte
    snap = regs_flat;
    i2c_start();
    write_byte(8'h84, -1, 0, ack);
    check("t6_addr_ack", ack, 1'b0);
    write_byte(8'h05, -1, 0, ack);
    check("t6_ptr_ack", ack, 1'b0);
`ifdef I2C_TARGET_FILTER_EN
    write_byte(8'hC3, 7, 1, ack);
    check("t6_filtered_ack", ack, 1'b0);
    check("t6_filtered_busy", busy, 1'b1);
    model[5] = 8'hC3;
`else
    write_byte(8'hC3, 7, 3, ack);
    check("t6b_glitch_nack", ack, 1'b1);
    check("t6b_glitch_busy", busy, 1'b0);
`endif
    i2c_stop();
    clks(10);
    check("t6_regs", regs_flat, model_flat());

    // Random traffic against the model.
    for (int it = 0; it < 4; it++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 2);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      write_txn("rnd_w", p);
      p = 8'($urandom_range(0, 255));
      read_txn("rnd_r", p, $urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
